// File: rtl/game_pixel_gen.sv
// Single-player paddle/ball game: frame-tick game state machine plus
// a registered pixel colour generator driven by the sync generator's raster.
module game_pixel_gen (
    input  logic        clkP,
    input  logic        reset,
    input  logic        video,
    input  logic [10:0] pixelX,
    input  logic [9:0]  pixelY,
    input  logic        btnUp,
    input  logic        btnDown,
    output logic [2:0]  rgb,
    output logic [7:0]  score,
    output logic [1:0]  lives
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_MISS = 2'd2,
        S_OVER = 2'd3
    } state_t;

    localparam logic [9:0] PAD_MAX  = 10'd408;
    localparam logic [9:0] PAD_STEP = 10'd4;
    localparam logic [9:0] BALL_X0  = 10'd316;
    localparam logic [9:0] BALL_Y0  = 10'd236;
    localparam logic [9:0] BALL_SPD = 10'd2;
    localparam logic [5:0] MISS_END = 6'd59;

    state_t      r_state;
    logic        r_tick;
    logic [9:0]  r_paddleY;
    logic [9:0]  r_ballX;
    logic [9:0]  r_ballY;
    logic        r_dx;
    logic        r_dy;
    logic [7:0]  r_score;
    logic [1:0]  r_lives;
    logic [5:0]  r_cnt;
    logic [2:0]  r_rgb;

    logic        w_hit;
    logic        w_miss;
    logic        w_dx_n;
    logic        w_dy_n;
    logic [9:0]  w_ballX_n;
    logic [9:0]  w_ballY_n;
    logic [9:0]  w_paddle_n;
    logic [10:0] w_relX;
    logic [9:0]  w_relY;
    logic        w_ball_px;
    logic        w_pad_px;
    logic        w_wall_px;
    logic [2:0]  w_rgb_n;

    // Hit window is tested at 11 bits so paddleY+71 cannot wrap.
    assign w_hit = !r_dx
                && (r_ballX >= 10'd34) && (r_ballX <= 10'd37)
                && ({1'b0, r_ballY} + 11'd7 >= {1'b0, r_paddleY})
                && ({1'b0, r_ballY} <= {1'b0, r_paddleY} + 11'd71);
    assign w_miss = !r_dx && (r_ballX <= 10'd1) && !w_hit;

    always_comb begin
        w_dx_n = r_dx;
        if (w_hit)
            w_dx_n = 1'b1;
        else if (r_dx && r_ballX >= 10'd630)
            w_dx_n = 1'b0;
    end

    always_comb begin
        w_dy_n = r_dy;
        if (!r_dy && r_ballY <= 10'd1)
            w_dy_n = 1'b1;
        else if (r_dy && r_ballY >= 10'd470)
            w_dy_n = 1'b0;
    end

    assign w_ballX_n = w_dx_n ? r_ballX + BALL_SPD : r_ballX - BALL_SPD;
    assign w_ballY_n = w_dy_n ? r_ballY + BALL_SPD : r_ballY - BALL_SPD;

    always_comb begin
        w_paddle_n = r_paddleY;
        if (btnUp && !btnDown)
            w_paddle_n = (r_paddleY < PAD_STEP) ? 10'd0 : r_paddleY - PAD_STEP;
        else if (btnDown && !btnUp)
            w_paddle_n = (r_paddleY > PAD_MAX - PAD_STEP) ? PAD_MAX
                                                          : r_paddleY + PAD_STEP;
    end

    always_ff @(posedge clkP) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tick    <= 1'b0;
            r_paddleY <= 10'd204;
            r_ballX   <= BALL_X0;
            r_ballY   <= BALL_Y0;
            r_dx      <= 1'b1;
            r_dy      <= 1'b1;
            r_score   <= 8'd0;
            r_lives   <= 2'd3;
            r_cnt     <= 6'd0;
        end else begin
            r_tick <= (pixelX == 11'd0) && (pixelY == 10'd480);
            if (r_tick) begin
                unique case (r_state)
                    S_IDLE: begin
                        r_paddleY <= w_paddle_n;
                        if (btnUp || btnDown)
                            r_state <= S_PLAY;
                    end
                    S_PLAY: begin
                        r_paddleY <= w_paddle_n;
                        if (w_miss) begin
                            r_lives <= r_lives - 2'd1;
                            if (r_lives == 2'd1) begin
                                r_state <= S_OVER;
                            end else begin
                                r_state <= S_MISS;
                                r_ballX <= BALL_X0;
                                r_ballY <= BALL_Y0;
                                r_dx    <= 1'b1;
                                r_dy    <= 1'b1;
                                r_cnt   <= 6'd0;
                            end
                        end else begin
                            r_dx    <= w_dx_n;
                            r_dy    <= w_dy_n;
                            r_ballX <= w_ballX_n;
                            r_ballY <= w_ballY_n;
                            if (w_hit)
                                r_score <= r_score + 8'd1;
                        end
                    end
                    S_MISS: begin
                        r_paddleY <= w_paddle_n;
                        r_cnt     <= r_cnt + 6'd1;
                        if (r_cnt == MISS_END)
                            r_state <= S_PLAY;
                    end
                    S_OVER: begin
                        if (btnUp && btnDown) begin
                            r_state <= S_IDLE;
                            r_lives <= 2'd3;
                            r_score <= 8'd0;
                            r_ballX <= BALL_X0;
                            r_ballY <= BALL_Y0;
                            r_dx    <= 1'b1;
                            r_dy    <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Unsigned wrap of the offsets turns pixels left/above the ball into large values.
    assign w_relX    = pixelX - {1'b0, r_ballX};
    assign w_relY    = pixelY - r_ballY;
    assign w_ball_px = (w_relX < 11'd8) && (w_relY < 10'd8);
    assign w_pad_px  = (pixelX >= 11'd32) && (pixelX <= 11'd35)
                    && (pixelY >= r_paddleY)
                    && ({1'b0, pixelY} <= {1'b0, r_paddleY} + 11'd71);
    assign w_wall_px = (pixelX == 11'd638) || (pixelX == 11'd639);

    always_comb begin
        w_rgb_n = 3'b000;
        if (w_ball_px)
            w_rgb_n = 3'b100;
        else if (w_pad_px)
            w_rgb_n = 3'b010;
        else if (w_wall_px)
            w_rgb_n = 3'b111;
    end

    always_ff @(posedge clkP) begin
        if (reset)
            r_rgb <= 3'b000;
        else
            r_rgb <= video ? w_rgb_n : 3'b000;
    end

    assign rgb   = r_rgb;
    assign score = r_score;
    assign lives = r_lives;

endmodule

// File: tb/tb_game_pixel_gen.sv
// Scoreboard bench for game_pixel_gen: directed ticks and pixel probes,
// expectations queued at issue time and checked by a separate monitor.
module tb_game_pixel_gen;

    logic        clkP = 1'b0;
    logic        reset;
    logic        video;
    logic [10:0] pixelX;
    logic [9:0]  pixelY;
    logic        btnUp;
    logic        btnDown;
    logic [2:0]  rgb;
    logic [7:0]  score;
    logic [1:0]  lives;

    always #5 clkP = ~clkP;

    game_pixel_gen dut (
        .clkP    (clkP),
        .reset   (reset),
        .video   (video),
        .pixelX  (pixelX),
        .pixelY  (pixelY),
        .btnUp   (btnUp),
        .btnDown (btnDown),
        .rgb     (rgb),
        .score   (score),
        .lives   (lives)
    );

    localparam int K_RGB = 0, K_SCORE = 1, K_LIVES = 2, K_PAD = 3;
    localparam int K_BX = 4, K_BY = 5, K_ST = 6, K_DX = 7, K_CNT = 8, K_TICK = 9;
    localparam int ST_IDLE = 0, ST_PLAY = 1, ST_MISS = 2, ST_OVER = 3;

    typedef struct {
        int    kind;
        int    expv;
        string name;
        int    stamp;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clkP) cyc <= cyc + 1;

    function automatic int actual(int k);
        case (k)
            K_RGB:   return int'(rgb);
            K_SCORE: return int'(score);
            K_LIVES: return int'(lives);
            K_PAD:   return int'(dut.r_paddleY);
            K_BX:    return int'(dut.r_ballX);
            K_BY:    return int'(dut.r_ballY);
            K_ST:    return int'(dut.r_state);
            K_DX:    return int'(dut.r_dx);
            K_CNT:   return int'(dut.r_cnt);
            K_TICK:  return int'(dut.r_tick);
            default: return -1;
        endcase
    endfunction

    // Monitor: an entry is due once a rising edge has passed since it was issued.
    always @(negedge clkP) begin
        exp_t e;
        int   a;
        while (q.size() > 0 && q[0].stamp < cyc) begin
            e = q.pop_front();
            a = actual(e.kind);
            n_chk++;
            if (a != e.expv) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d", e.name, a, e.expv);
            end
        end
    end

    task automatic expect_v(input int k, input int v, input string nm);
        exp_t e;
        e.kind  = k;
        e.expv  = v;
        e.name  = nm;
        e.stamp = cyc;
        q.push_back(e);
    endtask

    task automatic tick(input logic u, input logic d);
        @(negedge clkP);
        btnUp   = u;
        btnDown = d;
        video   = 1'b0;
        pixelX  = 11'd0;
        pixelY  = 10'd480;
        @(negedge clkP);
        pixelX  = 11'd1;
    endtask

    task automatic ticks(input int n, input logic u, input logic d);
        repeat (n) tick(u, d);
    endtask

    task automatic pix(input int x, input int y, input logic v,
                       input int e, input string nm);
        logic [31:0] xv;
        logic [31:0] yv;
        xv = x;
        yv = y;
        @(negedge clkP);
        pixelX = xv[10:0];
        pixelY = yv[9:0];
        video  = v;
        expect_v(K_RGB, e, nm);
    endtask

    task automatic do_reset();
        @(negedge clkP);
        reset   = 1'b1;
        btnUp   = 1'b0;
        btnDown = 1'b0;
        video   = 1'b0;
        pixelX  = 11'd1;
        pixelY  = 10'd0;
        @(negedge clkP);
        reset   = 1'b0;
    endtask

    task automatic reset_vals(input string tag);
        expect_v(K_ST,    ST_IDLE, {tag, "_state"});
        expect_v(K_PAD,   204,     {tag, "_paddleY"});
        expect_v(K_BX,    316,     {tag, "_ballX"});
        expect_v(K_BY,    236,     {tag, "_ballY"});
        expect_v(K_DX,    1,       {tag, "_dx"});
        expect_v(K_SCORE, 0,       {tag, "_score"});
        expect_v(K_LIVES, 3,       {tag, "_lives"});
        expect_v(K_RGB,   0,       {tag, "_rgb"});
        expect_v(K_CNT,   0,       {tag, "_cnt"});
        expect_v(K_TICK,  0,       {tag, "_tick"});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        video   = 1'b0;
        btnUp   = 1'b0;
        btnDown = 1'b0;
        pixelX  = 11'd1;
        pixelY  = 10'd0;
        repeat (3) @(negedge clkP);
        reset_vals("rst");
        @(negedge clkP);
        reset = 1'b0;

        // Rendering at reset positions
        pix(316, 236, 1'b0, 0, "blank_ball");
        pix(316, 236, 1'b1, 4, "ball_tl");
        pix(323, 243, 1'b1, 4, "ball_br");
        pix(324, 236, 1'b1, 0, "ball_right");
        pix(315, 236, 1'b1, 0, "ball_left");
        pix(32, 204, 1'b1, 2, "pad_top");
        pix(35, 275, 1'b1, 2, "pad_bot");
        pix(36, 204, 1'b1, 0, "pad_right");
        pix(32, 276, 1'b1, 0, "pad_below");
        pix(638, 10, 1'b1, 7, "wall_638");
        pix(639, 10, 1'b1, 7, "wall_639");
        pix(637, 10, 1'b1, 0, "wall_637");
        pix(100, 100, 1'b1, 0, "bg");
        pix(1024 + 316, 236, 1'b1, 0, "ball_x10");
        pix(1024 + 32, 204, 1'b1, 0, "pad_x10");
        tick(1'b0, 1'b0);
        expect_v(K_ST, ST_IDLE, "idle_hold");
        expect_v(K_BX, 316, "idle_ball");

        // Paddle motion and clamp
        tick(1'b1, 1'b0);
        expect_v(K_PAD, 200, "pad_up");
        expect_v(K_ST, ST_PLAY, "start_play");
        tick(1'b0, 1'b1);
        expect_v(K_PAD, 204, "pad_dn1");
        ticks(51, 1'b0, 1'b1);
        expect_v(K_PAD, 408, "pad_dn52");
        ticks(8, 1'b0, 1'b1);
        expect_v(K_PAD, 408, "pad_clamp");
        expect_v(K_ST, ST_PLAY, "play_hold");
        tick(1'b1, 1'b1);
        expect_v(K_PAD, 408, "pad_both");

        // Paddle hit: ball reaches x=36 after 454 play ticks
        do_reset();
        tick(1'b1, 1'b1);
        expect_v(K_ST, ST_PLAY, "hit_start");
        expect_v(K_PAD, 204, "hit_pad");
        ticks(157, 1'b0, 1'b0);
        expect_v(K_BX, 630, "wall_reach");
        tick(1'b0, 1'b0);
        expect_v(K_BX, 628, "wall_bounce_x");
        expect_v(K_DX, 0, "wall_bounce_dx");
        ticks(296, 1'b0, 1'b0);
        expect_v(K_BX, 36, "hit_pre_x");
        expect_v(K_BY, 204, "hit_pre_y");
        expect_v(K_SCORE, 0, "hit_pre_score");
        tick(1'b0, 1'b0);
        expect_v(K_DX, 1, "hit_dx");
        expect_v(K_SCORE, 1, "hit_score");
        expect_v(K_BX, 38, "hit_x");
        expect_v(K_BY, 206, "hit_y");

        // Miss with paddle at top
        do_reset();
        tick(1'b1, 1'b0);
        ticks(50, 1'b1, 1'b0);
        expect_v(K_PAD, 0, "miss_pad0");
        ticks(422, 1'b0, 1'b0);
        expect_v(K_BX, 0, "miss_pre_x");
        expect_v(K_BY, 240, "miss_pre_y");
        expect_v(K_LIVES, 3, "miss_pre_lives");
        tick(1'b0, 1'b0);
        expect_v(K_LIVES, 2, "miss_lives");
        expect_v(K_ST, ST_MISS, "miss_state");
        expect_v(K_BX, 316, "miss_cx");
        expect_v(K_BY, 236, "miss_cy");
        expect_v(K_CNT, 0, "miss_cnt0");
        tick(1'b0, 1'b1);
        expect_v(K_PAD, 4, "miss_pad_dn");
        tick(1'b1, 1'b0);
        expect_v(K_PAD, 0, "miss_pad_up");
        ticks(57, 1'b0, 1'b0);
        expect_v(K_ST, ST_MISS, "miss_59");
        expect_v(K_CNT, 59, "miss_cnt59");
        expect_v(K_BX, 316, "miss_hold_x");
        tick(1'b0, 1'b0);
        expect_v(K_ST, ST_PLAY, "miss_resume");

        // Second and third miss, then game over and restart
        ticks(473, 1'b0, 1'b0);
        expect_v(K_LIVES, 1, "miss2_lives");
        expect_v(K_ST, ST_MISS, "miss2_state");
        ticks(60, 1'b0, 1'b0);
        expect_v(K_ST, ST_PLAY, "miss2_resume");
        ticks(473, 1'b0, 1'b0);
        expect_v(K_LIVES, 0, "over_lives");
        expect_v(K_ST, ST_OVER, "over_state");
        ticks(5, 1'b0, 1'b1);
        expect_v(K_BX, 0, "over_frz_x");
        expect_v(K_BY, 240, "over_frz_y");
        expect_v(K_PAD, 0, "over_frz_pad");
        expect_v(K_ST, ST_OVER, "over_hold");
        tick(1'b1, 1'b1);
        expect_v(K_LIVES, 3, "restart_lives");
        expect_v(K_SCORE, 0, "restart_score");
        expect_v(K_ST, ST_IDLE, "restart_state");
        expect_v(K_BX, 316, "restart_x");

        // Reset in the middle of a miss count, with a tick pending
        tick(1'b1, 1'b0);
        ticks(473, 1'b0, 1'b0);
        expect_v(K_ST, ST_MISS, "mid_state");
        ticks(30, 1'b0, 1'b0);
        expect_v(K_CNT, 30, "mid_cnt30");
        @(negedge clkP);
        @(negedge clkP);
        reset  = 1'b1;
        pixelX = 11'd0;
        pixelY = 10'd480;
        reset_vals("midrst");
        @(negedge clkP);
        reset  = 1'b0;
        pixelX = 11'd316;
        pixelY = 10'd236;
        video  = 1'b1;
        expect_v(K_RGB, 4, "post_rst_ball");
        pix(32, 204, 1'b1, 2, "post_rst_pad");
        pix(500, 300, 1'b1, 0, "post_rst_bg");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clkP);
        @(negedge clkP);
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/game_pixel_gen.md
GAME_PIXEL_GEN -- requirements
Module: game_pixel_gen

Interface
REQ-001 The module SHALL have port clkP, input, 1 bit: the pixel clock; all logic is clocked on its rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have port video, input, 1 bit: visible-area flag from the sync generator (1 = visible).
REQ-004 The module SHALL have port pixelX, input, 11 bits: current column, 0..799.
REQ-005 The module SHALL have port pixelY, input, 10 bits: current line, 0..524.
REQ-006 The module SHALL have port btnUp, input, 1 bit: paddle-up button, already debounced and active-high.
REQ-007 The module SHALL have port btnDown, input, 1 bit: paddle-down button, already debounced and active-high.
REQ-008 The module SHALL have port rgb, output, 3 bits: the pixel colour as {R,G,B}.
REQ-009 The module SHALL have port score, output, 8 bits: the binary hit counter.
REQ-010 The module SHALL have port lives, output, 2 bits: the remaining lives.
REQ-011 The module SHALL use one clock, clkP, with reset synchronous and active-high.

Function
REQ-012 The frame tick SHALL be a registered one-cycle pulse, asserted in the cycle after pixelX==0 && pixelY==480 is sampled; all game state SHALL change only on this tick.
REQ-013 The paddle SHALL occupy x 32..35 and y paddleY..paddleY+71, with paddleY 10 bits wide and within 0..408.
REQ-014 On a tick in PLAY: btnUp alone SHALL subtract 4 from paddleY, clamped to 0; btnDown alone SHALL add 4, clamped to 408; both or neither pressed SHALL leave paddleY unchanged.
REQ-015 The ball SHALL be 8x8 at (ballX, ballY), 10 bits each, with direction bits dx and dy (1 = increasing) and a speed of 2 px per tick on each axis.
REQ-016 On a PLAY tick, directions SHALL first be resolved from the current position, and the position SHALL then move by ±2 using the resolved directions.
REQ-017 Top wall: if dy==0 and ballY<=1, dy SHALL become 1.
REQ-018 Bottom wall: if dy==1 and ballY>=470, dy SHALL become 0.
REQ-019 Right wall: if dx==1 and ballX>=630, dx SHALL become 0.
REQ-020 Paddle hit: if dx==0, 34<=ballX<=37, ballY+7>=paddleY and ballY<=paddleY+71, then dx SHALL become 1 and score SHALL increment by 1 (wrapping 255 to 0).
REQ-021 Miss: if dx==0, ballX<=1 and there is no paddle hit, then lives SHALL decrement and the state SHALL go to MISS, or to OVER if lives was 1.
REQ-022 The state machine SHALL have states IDLE, PLAY, MISS and OVER.
REQ-023 IDLE SHALL go to PLAY on a tick with btnUp or btnDown high; the ball SHALL be held at centre until then.
REQ-024 PLAY SHALL go to MISS or OVER per REQ-021.
REQ-025 On entry to MISS, the ball SHALL reset to (316,236) with dx=1 and dy=1, and a 6-bit frame counter SHALL be cleared.
REQ-026 MISS SHALL count ticks and go to PLAY on the 60th tick; the paddle SHALL remain movable during MISS.
REQ-027 OVER SHALL freeze all motion; a tick with btnUp && btnDown SHALL restore lives=3, score=0 and the centre ball, and go to IDLE.
REQ-028 Rendering SHALL give the ball pixel (pixelX-ballX<8, pixelY-ballY<8) colour 3'b100 and the paddle pixel colour 3'b010, with the ball taking priority over the paddle.
REQ-029 Rendering SHALL give the right wall (pixelX 638..639) colour 3'b111, the background 3'b000, and any pixel with video==0 3'b000.
REQ-030 rgb SHALL be registered with exactly 1 clkP of latency from the pixelX/pixelY/video sample.
REQ-031 Pixel comparisons SHALL use pixelX zero-extended or compared at 11 bits, with no truncation of pixelX[10].

Reset
REQ-032 Reset SHALL set state=IDLE, paddleY=204, ballX=316, ballY=236, dx=1, dy=1, score=0, lives=3, rgb=0, the tick to 0 and the frame counter to 0.
REQ-033 Reset SHALL override any in-progress MISS count or tick in the same cycle.

Verification
REQ-034 Reset, then drive a full frame with no buttons: rgb shall be 0 during blanking, 3'b100 at (316..323, 236..243), 3'b010 at (32..35, 204..275), and the state shall stay IDLE.
REQ-035 Press btnUp for 1 tick, then hold btnDown for 60 ticks: the state shall be PLAY, and paddleY shall go 204, then 200, then reach and hold at 408.
REQ-036 Start PLAY with paddleY=204 and the ball arriving at ballX=36, ballY=240, dx=0: dx shall become 1, score shall be 1 and ballX shall be 38 after that tick.
REQ-037 Use the same approach as REQ-036 with paddleY=0: lives shall go to 2 at ballX<=1, the ball shall be centred, and PLAY shall resume exactly 60 ticks later.
REQ-038 Cause three misses: the state shall be OVER and motion frozen; then press btnUp+btnDown together: lives shall be 3, score 0, and the state IDLE.
REQ-039 Assert reset mid-MISS at count 30: all values shall equal the REQ-032 values on the next cycle, and rgb latency shall be 1 cycle.
